// File: rtl/result_writer.sv
// result_writer
// Write-back path from the PE array into a byte-wide buffer. It takes a packed
// MaxWidth-lane result vector and writes it out one byte per cycle to
// consecutive buffer addresses. The address range runs from startAddr to
// finalAddr inclusive and wraps at the top of the buffer. The sticky
// "finished" flag rises once the last byte has gone out.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   writeBackEn  start request, sampled only while idle
//   startAddr    first buffer address, captured at start
//   finalAddr    last buffer address (inclusive), captured at start
//   dataInValid  PE result vector valid
//   dataIn       packed vector, lane i = bits [(i+1)*DataWidth-1 -: DataWidth]
//   dataInReady  a vector can be accepted this cycle
//   writeEn      buffer write strobe
//   writeAddr    buffer write address (0 when not writing)
//   writeData    buffer write byte (0 when not writing)
//   busy         high whenever not idle
//   finished     sticky done flag, cleared by the next accepted start
module result_writer #(
    parameter int MaxWidth  = 9,
    parameter int Depth     = 32,
    parameter int DataWidth = 8,
    parameter int AddrWidth = $clog2(Depth),
    parameter int LaneWidth = $clog2(MaxWidth)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          writeBackEn,
    input  logic [AddrWidth-1:0]          startAddr,
    input  logic [AddrWidth-1:0]          finalAddr,
    input  logic                          dataInValid,
    input  logic [MaxWidth*DataWidth-1:0] dataIn,
    output logic                          dataInReady,
    output logic                          writeEn,
    output logic [AddrWidth-1:0]          writeAddr,
    output logic [DataWidth-1:0]          writeData,
    output logic                          busy,
    output logic                          finished
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCEPT = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [LaneWidth-1:0] LAST_LANE = LaneWidth'(MaxWidth - 1);

    logic [1:0]                    state_reg, state_next;
    logic [AddrWidth-1:0]          ptr_reg,   ptr_next;
    logic [AddrWidth-1:0]          end_reg,   end_next;
    logic [LaneWidth-1:0]          lane_reg,  lane_next;
    logic [MaxWidth*DataWidth-1:0] vec_reg,   vec_next;
    logic                          fin_reg,   fin_next;

    // Split the held vector into lanes so the current byte is a plain mux.
    logic [DataWidth-1:0] lanes [MaxWidth];

    genvar gi;
    generate
        for (gi = 0; gi < MaxWidth; gi++) begin : g_lane
            assign lanes[gi] = vec_reg[(gi+1)*DataWidth-1 -: DataWidth];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        end_next   = end_reg;
        lane_next  = lane_reg;
        vec_next   = vec_reg;
        fin_next   = fin_reg;
        case (state_reg)
            IDLE: begin
                if (writeBackEn) begin
                    ptr_next   = startAddr;
                    end_next   = finalAddr;
                    fin_next   = 1'b0;
                    state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                if (dataInValid) begin
                    vec_next   = dataIn;
                    lane_next  = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // Depth is a power of two, so natural overflow gives the wrap.
                ptr_next = ptr_reg + AddrWidth'(1);
                if (ptr_reg == end_reg) begin
                    // Last byte of the range: any remaining lanes are dropped.
                    state_next = DONE;
                end else if (lane_reg == LAST_LANE) begin
                    state_next = ACCEPT;
                end else begin
                    lane_next = lane_reg + LaneWidth'(1);
                end
            end
            DONE: begin
                fin_next   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            end_reg   <= '0;
            lane_reg  <= '0;
            vec_reg   <= '0;
            fin_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            end_reg   <= end_next;
            lane_reg  <= lane_next;
            vec_reg   <= vec_next;
            fin_reg   <= fin_next;
        end
    end

    // All outputs decode from registered state, so an asynchronous reset
    // drops them in the same instant.
    assign dataInReady = (state_reg == ACCEPT);
    assign writeEn     = (state_reg == WRITE);
    assign busy        = (state_reg != IDLE);
    assign finished    = fin_reg;
    assign writeAddr   = writeEn ? ptr_reg : '0;
    assign writeData   = writeEn ? lanes[lane_reg] : '0;

endmodule

// File: tb/tb_result_writer.sv
module tb_result_writer;

    localparam int MW = 9;
    localparam int DP = 32;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int LW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             writeBackEn;
    logic [AW-1:0]    startAddr;
    logic [AW-1:0]    finalAddr;
    logic             dataInValid;
    logic [MW*DW-1:0] dataIn;
    logic             dataInReady;
    logic             writeEn;
    logic [AW-1:0]    writeAddr;
    logic [DW-1:0]    writeData;
    logic             busy;
    logic             finished;

    int n_checks = 0;
    int n_errors = 0;
    int ready_cycles = 0;

    logic [AW+DW-1:0] exp_q [$];

    result_writer #(
        .MaxWidth (MW),
        .Depth    (DP),
        .DataWidth(DW),
        .AddrWidth(AW),
        .LaneWidth(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .writeBackEn(writeBackEn),
        .startAddr  (startAddr),
        .finalAddr  (finalAddr),
        .dataInValid(dataInValid),
        .dataIn     (dataIn),
        .dataInReady(dataInReady),
        .writeEn    (writeEn),
        .writeAddr  (writeAddr),
        .writeData  (writeData),
        .busy       (busy),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Buffer-side monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (dataInReady) ready_cycles++;
        if (writeEn) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", exp_q.size(), 1);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", writeAddr, e[AW+DW-1:DW]);
                check("wr_data", writeData, e[DW-1:0]);
                $display("write addr=%0d data=0x%02h", writeAddr, writeData);
            end
        end else begin
            check("idle_addr", writeAddr, 0);
            check("idle_data", writeData, 0);
        end
    end

    // mode 0: random lanes, mode 1: lane i = 0x11*(i+1).
    // stall: cycles of dataInValid=0 in ACCEPT before the first vector.
    // poke: pulse writeBackEn with other addresses during the first vector's writes.
    task automatic run_xfer(input int s, input int f, input int mode, input int stall,
                            input bit poke);
        int n, nvec, rem, k;
        logic [MW*DW-1:0] vec;
        n    = ((f - s) & (DP - 1)) + 1;
        nvec = (n + MW - 1) / MW;
        rem  = n;
        @(negedge clk);
        writeBackEn = 1'b1;
        startAddr   = AW'(s);
        finalAddr   = AW'(f);
        @(negedge clk);
        writeBackEn  = 1'b0;
        ready_cycles = 0;
        check("busy_after_start", busy, 1);
        check("finished_cleared", finished, 0);
        for (int c = 0; c < stall; c++) begin
            check("stall_ready", dataInReady, 1);
            check("stall_no_write", writeEn, 0);
            @(negedge clk);
        end
        for (int v = 0; v < nvec; v++) begin
            for (int l = 0; l < MW; l++)
                vec[l*DW +: DW] = (mode == 1) ? DW'(8'h11 * (l + 1)) : DW'($urandom_range(0, 255));
            k = (rem < MW) ? rem : MW;
            for (int l = 0; l < k; l++)
                exp_q.push_back({AW'(s + v*MW + l), vec[l*DW +: DW]});
            rem -= k;
            dataIn      = vec;
            dataInValid = 1'b1;
            for (int t = 0; t < 60 && !dataInReady; t++) @(negedge clk);
            if (!dataInReady) check("ready_timeout", dataInReady, 1);
            $display("vector %0d sent: 0x%018h", v, vec);
            @(negedge clk);
            if (v == 0 && poke) begin
                writeBackEn = 1'b1;
                startAddr   = AW'(s + 7);
                finalAddr   = AW'(f + 3);
                @(negedge clk);
                writeBackEn = 1'b0;
            end
        end
        dataInValid = 1'b0;
        for (int t = 0; t < 100 && busy; t++) @(negedge clk);
        check("done_not_busy", busy, 0);
        check("finished_set", finished, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("transfer start=%0d final=%0d bytes=%0d done", s, f, n);
    endtask

    initial begin
        rst         = 1'b1;
        writeBackEn = 1'b0;
        startAddr   = '0;
        finalAddr   = '0;
        dataInValid = 1'b0;
        dataIn      = '0;
        repeat (2) @(negedge clk);
        check("rst_writeEn", writeEn, 0);
        check("rst_addr", writeAddr, 0);
        check("rst_data", writeData, 0);
        check("rst_ready", dataInReady, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        rst = 1'b0;

        // Exact-fit single vector
        run_xfer(0, 8, 1, 0, 1'b0);
        check("t1_ready_cycles", ready_cycles, 1);

        // Partial last vector
        run_xfer(4, 14, 0, 0, 1'b0);
        check("t2_ready_cycles", ready_cycles, 2);

        // Wrap-around
        run_xfer(28, 2, 1, 0, 1'b0);

        // Backpressure + single byte (random lane 0 covers the data path)
        run_xfer(5, 5, 0, 10, 1'b0);

        // Ignored start request mid-WRITE
        run_xfer(0, 8, 0, 0, 1'b1);

        // Full-buffer range
        run_xfer(10, 9, 0, 0, 1'b0);
        check("full_ready_cycles", ready_cycles, 4);

        // dataInValid while idle: no transfer, finished stays set
        dataInValid = 1'b1;
        dataIn      = {MW{8'h5A}};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_valid_busy", busy, 0);
            check("idle_valid_finished", finished, 1);
        end
        dataInValid = 1'b0;

        // Asynchronous reset during the 4th write of a 9-byte transfer
        @(negedge clk);
        writeBackEn = 1'b1;
        startAddr   = 5'd0;
        finalAddr   = 5'd8;
        @(negedge clk);
        writeBackEn = 1'b0;
        dataIn      = {8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        for (int l = 0; l < MW; l++) exp_q.push_back({AW'(l), DW'(8'h11 * (l + 1))});
        dataInValid = 1'b1;
        @(negedge clk);
        dataInValid = 1'b0;
        for (int t = 0; t < 60 && !(writeEn && writeAddr == 5'd3); t++) @(negedge clk);
        check("reach_4th_write", writeAddr, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_writeEn", writeEn, 0);
        check("arst_busy", busy, 0);
        check("arst_finished", finished, 0);
        check("arst_ready", dataInReady, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);

        run_xfer(0, 8, 1, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Write-back counterpart of the buffer-to-PE operand router: accepts packed MaxWidth-byte result vectors from the PE array and unpacks them into a byte-wide buffer, one byte per cycle.
- Writes occupy consecutive addresses from startAddr through finalAddr inclusive, with wrap-around at the top of the buffer.
- Signals finished when the last byte has been written.

Parameters:
- MaxWidth, 9, bytes per packed input vector (lanes).
- Depth, 32, buffer depth in bytes; must be a power of two.
- DataWidth, 8, bits per lane/byte.
- AddrWidth, $clog2(Depth), buffer address width.
- LaneWidth, $clog2(MaxWidth), lane counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- writeBackEn  input  1  start request; sampled only in IDLE.
- startAddr  input  AddrWidth  first buffer address to write; captured at start.
- finalAddr  input  AddrWidth  last buffer address to write, inclusive; captured at start.
- dataInValid  input  1  PE result vector valid.
- dataIn  input  MaxWidth*DataWidth  packed vector; lane i = bits [(i+1)*DataWidth-1 -: DataWidth].
- dataInReady  output  1  block can accept a vector this cycle.
- writeEn  output  1  buffer write strobe.
- writeAddr  output  AddrWidth  buffer write address.
- writeData  output  DataWidth  buffer write byte.
- busy  output  1  high in every state except IDLE.
- finished  output  1  sticky done flag.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, finished=0, pointer=0, lane counter=0, vector register=0; outputs writeEn=0, writeAddr=0, writeData=0, dataInReady=0, busy=0. Reset mid-transfer aborts immediately; no further writes occur.
- Output timing: dataInReady=(state==ACCEPT), writeEn=(state==WRITE), busy=(state!=IDLE), all decoded from registered state. writeAddr=pointer and writeData=vecReg lane[laneCnt] while in WRITE; both are 0 otherwise.
- Buffer protocol: the buffer samples writeAddr/writeData on the rising edge at which writeEn is high.
- IDLE:
  - On writeBackEn=1: pointer<=startAddr; endReg<=finalAddr; finished<=0; go to ACCEPT.
  - dataInValid is ignored in IDLE.
- ACCEPT:
  - Handshake occurs on an edge with dataInValid=1 (dataInReady=1 in this state).
  - On handshake: vecReg<=dataIn; laneCnt<=0; go to WRITE.
  - Without handshake, stay in ACCEPT indefinitely.
- WRITE (one byte per cycle):
  - The lane-0 write is presented in the cycle immediately after the handshake edge.
  - Each edge: pointer<=pointer+1 modulo Depth, so Depth-1 wraps to 0.
  - If pointer==endReg: go to DONE. Remaining lanes of the vector are discarded.
  - Else if laneCnt==MaxWidth-1: go to ACCEPT.
  - Else: laneCnt<=laneCnt+1.
- DONE: finished<=1; go to IDLE. Exactly one cycle; writeEn=0.
- finished remains high in IDLE until the next accepted writeBackEn clears it.
- Byte count and address range:
  - Total bytes written = ((finalAddr-startAddr) mod Depth)+1.
  - startAddr==finalAddr writes exactly 1 byte.
  - finalAddr==startAddr-1 (mod Depth) writes Depth bytes.
  - Vectors required = ceil(bytes/MaxWidth).
- writeBackEn while busy is ignored; startAddr/finalAddr changes after capture have no effect.
- Minimum cycle cost per full vector = 1 (ACCEPT with valid) + MaxWidth (WRITE).

Test Plan:
- Single vector, exact fit: start=0, final=8, one vector lanes 0x11..0x99 with valid held high -> 9 consecutive writeEn cycles, addr 0..8, data 0x11,0x22,...,0x99; finished=1 one cycle after the last write; dataInReady high for exactly 1 cycle.
- Partial last vector: start=4, final=14 (11 bytes), two vectors -> writes to addr 4..12 from vector A; 2 writes to addr 13,14 carrying vector B lanes 0,1; B lanes 2..8 are never written; dataInReady asserts exactly twice.
- Wrap-around: start=28, final=2 -> writes to addr 28,29,30,31,0,1,2 (7 bytes) carrying lanes 0..6; finished=1.
- Backpressure and single byte: start=final=5; hold dataInValid=0 for 10 cycles -> stays in ACCEPT with dataInReady=1 and no writes; then valid with lane0=0xA5 -> exactly one write of addr 5, data 0xA5.
- Ignored inputs: pulse writeBackEn mid-WRITE with different addresses -> sequence unchanged. dataInValid=1 while in IDLE -> no transfer. finished stays 1 until the next start.
- Reset mid-operation: assert rst asynchronously during the 4th write of a 9-byte transfer -> writeEn, busy, finished, dataInReady drop to 0 immediately, with no further writes. A new start=0, final=8 then completes normally.
